autosa_cmac_reg_group_ctrl: RTL
===============================

Name: autosa_cmac_reg_group_ctrl

Overview:
Ping-pong register-group sequencer for the CMAC core. Tracks the execution state of the two shadow register groups (0/1), decides which group the datapath consumes next, and drives the datapath op-enable and the layer-done interrupt. Supplies the read-only consumer, status_0 and status_1 fields of the CMAC single-register block. Takes the software-owned producer pointer from that block.

Parameters:
LAUNCH_DLY, 2, cycles from a group being seen PENDING (as consumer, datapath idle) to dp_op_en rising; range 1..15.
TIMEOUT_W, 16, watchdog counter width; used only with the optional feature.
TIMEOUT_CYC, 16'hFFFF, RUNNING cycles before the watchdog fires; used only with the optional feature.

Ports:
autosa_core_clk  in  1  core clock; the only clock.
autosa_core_rstn  in  1  asynchronous active-low reset.
producer  in  1  software register-group pointer from the single-register block.
op_en_wr  in  2  one-cycle pulse per group: write to that group's OP_ENABLE register.
op_en_wdata  in  1  write data bit 0 accompanying op_en_wr.
dp_done  in  1  one-cycle datapath layer-complete pulse.
consumer  out  1  group currently owned or next owned by the datapath.
status_0  out  2  group 0 state: 0 IDLE, 1 PENDING, 2 RUNNING.
status_1  out  2  group 1 state, same encoding.
dp_op_en  out  1  level; high while the consumer group is RUNNING.
dp_grp  out  1  group index the datapath must read its config from; equals consumer.
prod_busy  out  1  combinational; high when the producer group state is not IDLE.
done_intr  out  1  one-cycle pulse on layer completion.
done_grp  out  1  group that completed; valid with done_intr.
err_wr  out  1  one-cycle pulse on a rejected op_en write.
err_done  out  1  one-cycle pulse on dp_done received while no group is RUNNING.
timeout  out  1  one-cycle watchdog pulse; tied 0 without the optional feature.

Behaviour:
- Reset (async, autosa_core_rstn low): status_0 = status_1 = IDLE, consumer = 0, dp_op_en = 0, launch counter = 0, all pulse outputs = 0, watchdog = 0. Reset mid-layer aborts the layer immediately; the datapath must treat dp_op_en falling as abort.
- Group FSM, per group g:
  - IDLE -> PENDING on op_en_wr[g] with op_en_wdata = 1.
  - op_en_wr[g] with op_en_wdata = 0 in IDLE: no effect, no error.
  - op_en_wr[g] in PENDING or RUNNING: ignored; err_wr pulses the next cycle.
- Launch:
  - When state[consumer] = PENDING and dp_op_en = 0, the launch counter counts up.
  - On the cycle the counter reaches LAUNCH_DLY, state[consumer] -> RUNNING and dp_op_en is registered high on that edge.
  - The counter clears whenever the launch condition is false.
- Completion: dp_done while state[consumer] = RUNNING, on the next edge:
  - state[consumer] -> IDLE, dp_op_en -> 0, consumer toggles.
  - done_intr = 1 and done_grp = old consumer, for exactly one cycle.
- dp_done with no RUNNING group: ignored; err_done pulses one cycle.
- Simultaneous events:
  - op_en_wr to the RUNNING group in the same cycle as dp_done: the write is rejected (err_wr) because the state check uses pre-edge state.
  - op_en_wr to the other group in the same cycle as dp_done: accepted.
  - If the new consumer is PENDING after completion, its launch counter starts the following cycle, giving a back-to-back gap of LAUNCH_DLY+1 cycles.
- op_en writes to both groups in the same cycle: each is evaluated independently.
- The non-consumer group never leaves PENDING until consumer points at it; there is no out-of-order execution.
- producer does not affect sequencing. It only drives prod_busy.
- All outputs except prod_busy are registered.

Optional Feature:
AUTOSA_CMAC_REG_GROUP_TIMEOUT_EN.
- Defined: a TIMEOUT_W-bit watchdog counts cycles while dp_op_en = 1 and clears when dp_op_en = 0. On reaching TIMEOUT_CYC:
  - state[consumer] -> IDLE, dp_op_en -> 0, consumer toggles.
  - timeout pulses one cycle; done_intr is not asserted.
  - dp_done in the same cycle as the watchdog firing takes priority: normal completion, no timeout.
- Not defined: no watchdog logic; timeout is constant 0.

Test Plan:
- Reset, then op_en_wr = 2'b01 with op_en_wdata = 1 (LAUNCH_DLY = 2) -> status_0 = 1 next cycle; dp_op_en rises 2 cycles later with status_0 = 2; dp_grp = 0.
- dp_done after the first scenario -> next cycle status_0 = 0, consumer = 1, done_intr = 1 with done_grp = 0 for exactly one cycle.
- Program both groups, then issue dp_done twice -> group 0 runs, then group 1 launches LAUNCH_DLY+1 cycles after the first done_intr; consumer reads 0, 1, 0.
- op_en_wr = 2'b01 while group 0 is RUNNING, with simultaneous dp_done -> err_wr = 1, status_0 ends 0, no re-launch.
- dp_done at idle -> err_done = 1 for one cycle, no state change; assert reset while RUNNING -> dp_op_en = 0, consumer = 0, status = 0 immediately.
- With AUTOSA_CMAC_REG_GROUP_TIMEOUT_EN, TIMEOUT_CYC = 10 and no dp_done -> timeout pulses 10 cycles after dp_op_en rises; status = 0, consumer toggles, done_intr = 0.

Source files
------------

// File: rtl/autosa_cmac_reg_group_ctrl_if.sv
// -----------------------------------------------------------------------------
// autosa_cmac_reg_group_ctrl_if
//   Bundles the register-block and datapath signals of the CMAC ping-pong
//   register-group sequencer.
//
//   slave  modport : sequencer view (register writes and dp_done in,
//                    group status / datapath controls / pulses out)
//   master modport : environment view (register block + datapath)
//
//   Signals:
//     producer     software group pointer
//     op_en_wr     per-group OP_ENABLE write strobe
//     op_en_wdata  OP_ENABLE write data bit 0
//     dp_done      datapath layer-complete pulse
//     consumer     group owned / next owned by the datapath
//     status_0/1   group state (0 IDLE, 1 PENDING, 2 RUNNING)
//     dp_op_en     datapath enable level
//     dp_grp       group the datapath reads its config from
//     prod_busy    producer group is not IDLE
//     done_intr    layer-done pulse, done_grp = completed group
//     err_wr       rejected OP_ENABLE write pulse
//     err_done     dp_done with no RUNNING group pulse
//     timeout      watchdog pulse
// -----------------------------------------------------------------------------
interface autosa_cmac_reg_group_ctrl_if;
  logic       producer;
  logic [1:0] op_en_wr;
  logic       op_en_wdata;
  logic       dp_done;
  logic       consumer;
  logic [1:0] status_0;
  logic [1:0] status_1;
  logic       dp_op_en;
  logic       dp_grp;
  logic       prod_busy;
  logic       done_intr;
  logic       done_grp;
  logic       err_wr;
  logic       err_done;
  logic       timeout;

  modport slave (
    input  producer, op_en_wr, op_en_wdata, dp_done,
    output consumer, status_0, status_1, dp_op_en, dp_grp, prod_busy,
           done_intr, done_grp, err_wr, err_done, timeout
  );

  modport master (
    output producer, op_en_wr, op_en_wdata, dp_done,
    input  consumer, status_0, status_1, dp_op_en, dp_grp, prod_busy,
           done_intr, done_grp, err_wr, err_done, timeout
  );
endinterface

// File: rtl/autosa_cmac_reg_group_ctrl.sv
// -----------------------------------------------------------------------------
// autosa_cmac_reg_group_ctrl
//   Ping-pong register-group sequencer for the CMAC core. Tracks the state of
//   the two shadow register groups, hands them to the datapath strictly in
//   order (consumer pointer), drives dp_op_en and the layer-done interrupt.
//
//   Ports:
//     autosa_core_clk   core clock
//     autosa_core_rstn  asynchronous active-low reset
//     bus               autosa_cmac_reg_group_ctrl_if.slave (see interface)
//
//   Optional feature macro: AUTOSA_CMAC_REG_GROUP_TIMEOUT_EN
//     Defined     : TIMEOUT_W-bit watchdog aborts a layer after TIMEOUT_CYC
//                   RUNNING cycles and pulses timeout.
//     Not defined : no watchdog, timeout is constant 0.
// -----------------------------------------------------------------------------
module autosa_cmac_reg_group_ctrl #(
  parameter int unsigned          LAUNCH_DLY  = 2,
  parameter int unsigned          TIMEOUT_W   = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 16'hFFFF
) (
  input logic                          autosa_core_clk,
  input logic                          autosa_core_rstn,
  autosa_cmac_reg_group_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RUNNING = 2'd2
  } grp_state_t;

  localparam logic [3:0] LAUNCH_LAST = 4'(LAUNCH_DLY - 1);

  grp_state_t state_r     [2];
  grp_state_t state_nxt_s [2];
  grp_state_t cur_state_s;

  logic       consumer_r,  consumer_nxt_s;
  logic       dp_op_en_r,  dp_op_en_nxt_s;
  logic       settle_r,    settle_nxt_s;
  logic [3:0] launch_cnt_r, launch_cnt_nxt_s;
  logic       done_intr_r, done_intr_nxt_s;
  logic       done_grp_r,  done_grp_nxt_s;
  logic       err_wr_r,    err_wr_nxt_s;
  logic       err_done_r,  err_done_nxt_s;
  logic       timeout_r,   timeout_nxt_s;
  logic [1:0] wr_accept_s;
  logic [1:0] grp_busy_s;
  logic       wdog_fire_s;

  assign cur_state_s   = state_r[consumer_r];
  assign grp_busy_s[0] = (state_r[0] != ST_IDLE);
  assign grp_busy_s[1] = (state_r[1] != ST_IDLE);
  // A write is judged against the pre-edge state, so a write landing on the
  // edge that retires a group is still rejected.
  assign wr_accept_s   = bus.op_en_wr & {2{bus.op_en_wdata}} & ~grp_busy_s;

`ifdef AUTOSA_CMAC_REG_GROUP_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog_r;

  // Watchdog: counts RUNNING cycles, cleared whenever the datapath is idle.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      wdog_r <= '0;
    end else if (dp_op_en_r) begin
      wdog_r <= wdog_r + TIMEOUT_W'(1);
    end else begin
      wdog_r <= '0;
    end
  end

  assign wdog_fire_s = dp_op_en_r & (wdog_r == (TIMEOUT_CYC - TIMEOUT_W'(1)));
`else
  assign wdog_fire_s = 1'b0;
`endif

  // Next-state logic for both groups, launch counter and event pulses.
  always_comb begin
    state_nxt_s[0]   = state_r[0];
    state_nxt_s[1]   = state_r[1];
    consumer_nxt_s   = consumer_r;
    dp_op_en_nxt_s   = dp_op_en_r;
    settle_nxt_s     = 1'b0;
    launch_cnt_nxt_s = 4'd0;
    done_intr_nxt_s  = 1'b0;
    done_grp_nxt_s   = done_grp_r;
    timeout_nxt_s    = 1'b0;
    err_wr_nxt_s     = |(bus.op_en_wr & grp_busy_s);
    err_done_nxt_s   = bus.dp_done & (cur_state_s != ST_RUNNING);

    for (int g = 0; g < 2; g++) begin
      if (wr_accept_s[g]) begin
        state_nxt_s[g] = ST_PENDING;
      end else begin
        state_nxt_s[g] = state_r[g];
      end
    end

    // Writes only act on IDLE groups and the consumer handling below only on
    // PENDING/RUNNING, so the two never collide on the same group.
    case (cur_state_s)
      ST_PENDING: begin
        // settle_r holds the counter for one cycle after a hand-over, so a
        // back-to-back launch trails the previous done by LAUNCH_DLY+1.
        if (!dp_op_en_r && !settle_r) begin
          if (launch_cnt_r == LAUNCH_LAST) begin
            state_nxt_s[consumer_r] = ST_RUNNING;
            dp_op_en_nxt_s          = 1'b1;
          end else begin
            launch_cnt_nxt_s = launch_cnt_r + 4'd1;
          end
        end else begin
          launch_cnt_nxt_s = 4'd0;
        end
      end
      ST_RUNNING: begin
        // dp_done outranks a watchdog firing in the same cycle.
        if (bus.dp_done) begin
          state_nxt_s[consumer_r] = ST_IDLE;
          dp_op_en_nxt_s          = 1'b0;
          consumer_nxt_s          = ~consumer_r;
          settle_nxt_s            = 1'b1;
          done_intr_nxt_s         = 1'b1;
          done_grp_nxt_s          = consumer_r;
        end else if (wdog_fire_s) begin
          state_nxt_s[consumer_r] = ST_IDLE;
          dp_op_en_nxt_s          = 1'b0;
          consumer_nxt_s          = ~consumer_r;
          settle_nxt_s            = 1'b1;
          timeout_nxt_s           = 1'b1;
        end else begin
          dp_op_en_nxt_s = 1'b1;
        end
      end
      default: begin
        launch_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state_r[0]   <= ST_IDLE;
      state_r[1]   <= ST_IDLE;
      consumer_r   <= 1'b0;
      dp_op_en_r   <= 1'b0;
      settle_r     <= 1'b0;
      launch_cnt_r <= 4'd0;
      done_intr_r  <= 1'b0;
      done_grp_r   <= 1'b0;
      err_wr_r     <= 1'b0;
      err_done_r   <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r[0]   <= state_nxt_s[0];
      state_r[1]   <= state_nxt_s[1];
      consumer_r   <= consumer_nxt_s;
      dp_op_en_r   <= dp_op_en_nxt_s;
      settle_r     <= settle_nxt_s;
      launch_cnt_r <= launch_cnt_nxt_s;
      done_intr_r  <= done_intr_nxt_s;
      done_grp_r   <= done_grp_nxt_s;
      err_wr_r     <= err_wr_nxt_s;
      err_done_r   <= err_done_nxt_s;
      timeout_r    <= timeout_nxt_s;
    end
  end

  assign bus.consumer  = consumer_r;
  assign bus.dp_grp    = consumer_r;
  assign bus.status_0  = state_r[0];
  assign bus.status_1  = state_r[1];
  assign bus.dp_op_en  = dp_op_en_r;
  assign bus.done_intr = done_intr_r;
  assign bus.done_grp  = done_grp_r;
  assign bus.err_wr    = err_wr_r;
  assign bus.err_done  = err_done_r;
  assign bus.timeout   = timeout_r;
  assign bus.prod_busy = grp_busy_s[bus.producer];

endmodule
